acc_rr_scheduler: RTL and testbench
===================================

# acc_rr_scheduler

Round-robin scheduler that shares one FIXED_POINT_ACC instance (with external bias enabled) among NUM_REQ neuron requesters. It arbitrates pending requests and steers the winner's operand vector and bias onto the accumulator. It launches the accumulation, waits for completion with a watchdog, and returns the result to the winner with a one-cycle done pulse. It sits between a layer's neuron controllers and the shared accumulator datapath.

## Interface
- WIDTH, 8: operand/result width in bits (signed fixed point; the format is opaque to this block).
- NUM_INPUTS, 16: operands per accumulation.
- NUM_REQ, 4: number of requesters, ≥2.
- TIMEOUT, 255: maximum cycles spent in WAIT before abort; 0 disables the watchdog.

- CLK  in  1  clock, all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- REQ_IN  in  [NUM_REQ]  per-requester request level.
- REQ_VALUES_IN  in  signed [WIDTH-1:0] [NUM_REQ][NUM_INPUTS]  operand vectors, held stable by the requester while REQ_IN is high.
- REQ_BIAS_IN  in  signed [WIDTH-1:0] [NUM_REQ]  per-requester bias.
- GRANT_OUT  out  [NUM_REQ]  one-hot grant, or all-zero.
- DONE_OUT  out  [NUM_REQ]  one-cycle completion pulse to the granted requester.
- RESULT_OUT  out  signed [WIDTH-1:0]  result of the last completed operation, held until the next DONE.
- ERR_OUT  out  1  one-cycle pulse coincident with DONE when the watchdog aborts.
- BUSY_OUT  out  1  high in every state except IDLE.
- ACC_VALUES_OUT  out  signed [WIDTH-1:0] [NUM_INPUTS]  operand vector to the accumulator.
- ACC_EXT_OUT  out  signed [WIDTH-1:0]  bias to the accumulator.
- ACC_VALID_OUT  out  1  one-cycle launch pulse.
- ACC_VALUE_IN  in  signed [WIDTH-1:0]  accumulator result.
- ACC_VALID_IN  in  1  accumulator result valid.

## Operation
- States: IDLE, LAUNCH, WAIT, RELEASE.
- **IDLE:** if any REQ_IN bit is high, select the winner.
  - Winner is the first set bit at or after rr_ptr, scanning upward and wrapping modulo NUM_REQ.
  - Register grant_idx = winner; set rr_ptr = (winner+1) mod NUM_REQ.
  - Assert GRANT_OUT[winner]; go to LAUNCH.
  - If no request is pending, stay in IDLE.
- **LAUNCH:** assert ACC_VALID_OUT for exactly one cycle; clear the watchdog counter; go to WAIT.
- **WAIT:** the watchdog counter increments every cycle.
  - If ACC_VALID_IN is high: capture ACC_VALUE_IN into RESULT_OUT, pulse DONE_OUT[grant_idx], go to RELEASE.
  - Else if TIMEOUT≠0 and the counter reaches TIMEOUT: RESULT_OUT←0, pulse DONE_OUT[grant_idx] and ERR_OUT, go to RELEASE.
  - If ACC_VALID_IN arrives in the same cycle the counter reaches TIMEOUT, the valid result wins (no ERR).
- **RELEASE:** GRANT_OUT returns to all-zero; no arbitration occurs; go to IDLE.
  - This cycle gives the requester time to drop REQ_IN after DONE.
- **Operand steering:**
  - ACC_VALUES_OUT = REQ_VALUES_IN[grant_idx] and ACC_EXT_OUT = REQ_BIAS_IN[grant_idx], as a combinational mux on the registered grant_idx.
  - The mux drives the granted requester's data from LAUNCH through WAIT.
  - In IDLE and RELEASE the outputs show the last grant_idx (don't-care for the accumulator).
- **Arithmetic:** no arithmetic in this block; RESULT_OUT is a bit-exact copy of ACC_VALUE_IN.
- **Boundary conditions:**
  - ACC_VALID_IN outside WAIT is ignored, including a late result after a watchdog abort or after reset.
  - If the granted requester drops REQ_IN before DONE, the operation still completes and DONE still pulses.
  - A requester holding REQ_IN high through RELEASE is re-eligible in IDLE, but only after all other pending requesters in round-robin order.
  - All requests simultaneously pending are served in strict rotation; no requester waits more than NUM_REQ-1 operations.
  - Watchdog counter width is $clog2(TIMEOUT+1); it saturates rather than wraps.
- **Reset (asynchronous, including mid-operation):**
  - State←IDLE, rr_ptr←0, grant_idx←0, watchdog counter←0.
  - GRANT_OUT←0, DONE_OUT←0, ERR_OUT←0, ACC_VALID_OUT←0, BUSY_OUT←0, RESULT_OUT←0.
  - The accumulator shares RSTN, so no flush is required.

## Timing
- All outputs are registered except ACC_VALUES_OUT and ACC_EXT_OUT, which are muxed from registered grant_idx.
- Request to grant: REQ_IN sampled high at edge n in IDLE → GRANT_OUT high after edge n.
- Grant to launch: ACC_VALID_OUT high for the cycle after edge n+1.
- Completion: ACC_VALID_IN sampled at edge m → DONE_OUT, RESULT_OUT and (if applicable) ERR_OUT update after edge m; GRANT_OUT drops after edge m+1.
- Scheduler overhead per operation is 4 cycles plus the accumulator latency L (FIXED_POINT_ACC: roughly NUM_INPUTS+3).
- Back-to-back throughput: one operation every L+4 cycles.
- Watchdog: DONE/ERR at most TIMEOUT cycles after LAUNCH.

## Test plan
- **Single requester:** REQ_IN=0001, values all 1.0, bias 0.5, accumulator model L=19 → GRANT_OUT=0001 next cycle, ACC_VALID_OUT one pulse, DONE_OUT=0001 one pulse with RESULT_OUT=16.5 encoding, BUSY_OUT low again 2 cycles after DONE.
- **Round-robin fairness:** REQ_IN=1111 held, each requester drops REQ after its DONE → grants in order 0,1,2,3; with REQ_IN=1111 held permanently, order 0,1,2,3,0,1 with no repeats.
- **Pointer wrap:** serve requester 3, then REQ_IN=1001 → requester 0 granted first, then 3.
- **Watchdog:** TIMEOUT=8, accumulator never responds → DONE_OUT and ERR_OUT pulse together 8 cycles after launch, RESULT_OUT=0; a late ACC_VALID_IN at cycle 12 is ignored with no extra DONE.
- **Tie at timeout:** ACC_VALID_IN asserted exactly on the TIMEOUT cycle → DONE with the captured value, ERR_OUT stays 0.
- **Reset mid-WAIT:** RSTN low for 1 cycle during WAIT → all outputs 0 immediately (asynchronously); a following ACC_VALID_IN produces no DONE; the next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-point accumulator among NUM_REQ requesters.
// Arbitrates, steers the winner's operands, launches, waits with a watchdog, returns the result.
module acc_rr_scheduler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [NUM_REQ-1:0]      REQ_IN,
    input  logic signed [WIDTH-1:0] REQ_VALUES_IN [NUM_REQ][NUM_INPUTS],
    input  logic signed [WIDTH-1:0] REQ_BIAS_IN [NUM_REQ],
    output logic [NUM_REQ-1:0]      GRANT_OUT,
    output logic [NUM_REQ-1:0]      DONE_OUT,
    output logic signed [WIDTH-1:0] RESULT_OUT,
    output logic                    ERR_OUT,
    output logic                    BUSY_OUT,
    output logic signed [WIDTH-1:0] ACC_VALUES_OUT [NUM_INPUTS],
    output logic signed [WIDTH-1:0] ACC_EXT_OUT,
    output logic                    ACC_VALID_OUT,
    input  logic signed [WIDTH-1:0] ACC_VALUE_IN,
    input  logic                    ACC_VALID_IN
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntSat = (TIMEOUT > 0) ? CntW'(TIMEOUT) : {CntW{1'b1}};
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StRelease} state_e;

    state_e          state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] grant_idx;
    logic [CntW-1:0] wd_cnt;

    logic               any_req;
    logic               found;
    logic [IdxW-1:0]    cand;
    logic [IdxW-1:0]    winner;
    logic [NUM_REQ-1:0] winner_oh;
    logic [IdxW-1:0]    next_ptr;
    logic [CntW-1:0]    wd_inc;
    logic               timed_out;

    // First pending request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        any_req = |REQ_IN;
        found   = 1'b0;
        cand    = '0;
        winner  = rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdxW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && REQ_IN[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
        next_ptr          = (winner == LastIdx) ? '0 : winner + IdxW'(1);
    end

    // Saturating watchdog; a zero TIMEOUT never fires.
    always_comb begin
        wd_inc    = (wd_cnt == CntSat) ? wd_cnt : wd_cnt + CntW'(1);
        timed_out = (TIMEOUT != 0) && (wd_inc == CntW'(TIMEOUT));
    end

    assign ACC_VALUES_OUT = REQ_VALUES_IN[grant_idx];
    assign ACC_EXT_OUT    = REQ_BIAS_IN[grant_idx];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state         <= StIdle;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            wd_cnt        <= '0;
            GRANT_OUT     <= '0;
            DONE_OUT      <= '0;
            RESULT_OUT    <= '0;
            ERR_OUT       <= 1'b0;
            BUSY_OUT      <= 1'b0;
            ACC_VALID_OUT <= 1'b0;
        end else begin
            DONE_OUT      <= '0;
            ERR_OUT       <= 1'b0;
            ACC_VALID_OUT <= 1'b0;
            case (state)
                StIdle: begin
                    if (any_req) begin
                        grant_idx <= winner;
                        rr_ptr    <= next_ptr;
                        GRANT_OUT <= winner_oh;
                        BUSY_OUT  <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    ACC_VALID_OUT <= 1'b1;
                    wd_cnt        <= '0;
                    state         <= StWait;
                end
                StWait: begin
                    wd_cnt <= wd_inc;
                    // A result arriving on the timeout cycle still wins.
                    if (ACC_VALID_IN) begin
                        RESULT_OUT <= ACC_VALUE_IN;
                        DONE_OUT   <= GRANT_OUT;
                        state      <= StRelease;
                    end else if (timed_out) begin
                        RESULT_OUT <= '0;
                        DONE_OUT   <= GRANT_OUT;
                        ERR_OUT    <= 1'b1;
                        state      <= StRelease;
                    end
                end
                StRelease: begin
                    GRANT_OUT <= '0;
                    BUSY_OUT  <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    grant_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(GRANT_OUT));
    done_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(DONE_OUT));
    err_with_done: assert property (@(posedge CLK) disable iff (!RSTN) ERR_OUT |-> (|DONE_OUT));
    launch_in_wait: assert property (@(posedge CLK) disable iff (!RSTN)
                                     ACC_VALID_OUT |-> (state == StWait));

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Directed bench: table of arbitration/steering vectors on a long-timeout instance,
// plus hand sequences for watchdog, tie, dropped request and reset on a short-timeout pair.
module tb_acc_rr_scheduler;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] vals [4][16];
    logic signed [7:0] bias [4];

    logic [3:0]        req_a = '0, req_b = '0;
    logic signed [7:0] acc_val_a = '0, acc_val_b = '0;
    logic              acc_vld_a = 1'b0, acc_vld_b = 1'b0;

    logic [3:0]        grant_a, done_a, grant_b, done_b;
    logic signed [7:0] result_a, result_b, ext_a, ext_b;
    logic              err_a, busy_a, launch_a, err_b, busy_b, launch_b;
    logic signed [7:0] avals_a [16];
    logic signed [7:0] avals_b [16];

    acc_rr_scheduler #(.WIDTH(8), .NUM_INPUTS(16), .NUM_REQ(4), .TIMEOUT(255)) dut_a (
        .CLK(clk), .RSTN(rstn), .REQ_IN(req_a), .REQ_VALUES_IN(vals), .REQ_BIAS_IN(bias),
        .GRANT_OUT(grant_a), .DONE_OUT(done_a), .RESULT_OUT(result_a), .ERR_OUT(err_a),
        .BUSY_OUT(busy_a), .ACC_VALUES_OUT(avals_a), .ACC_EXT_OUT(ext_a),
        .ACC_VALID_OUT(launch_a), .ACC_VALUE_IN(acc_val_a), .ACC_VALID_IN(acc_vld_a)
    );

    acc_rr_scheduler #(.WIDTH(8), .NUM_INPUTS(16), .NUM_REQ(4), .TIMEOUT(8)) dut_b (
        .CLK(clk), .RSTN(rstn), .REQ_IN(req_b), .REQ_VALUES_IN(vals), .REQ_BIAS_IN(bias),
        .GRANT_OUT(grant_b), .DONE_OUT(done_b), .RESULT_OUT(result_b), .ERR_OUT(err_b),
        .BUSY_OUT(busy_b), .ACC_VALUES_OUT(avals_b), .ACC_EXT_OUT(ext_b),
        .ACC_VALID_OUT(launch_b), .ACC_VALUE_IN(acc_val_b), .ACC_VALID_IN(acc_vld_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]        req;
        int                lat;
        logic signed [7:0] acc;
        logic [3:0]        grant;
        logic signed [7:0] v0;
        logic signed [7:0] v15;
        logic signed [7:0] bias;
        logic signed [7:0] res;
    } vec_t;

    vec_t tbl [15];
    logic early;

    initial begin
        // Q5.2 operands: requester 0 holds 1.0 everywhere with bias 0.5.
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 16; j++)
                vals[r][j] = (r == 0) ? 8'sd4 : 8'(r * 16 + j);
        bias[0] = 8'sd2;
        bias[1] = -8'sd3;
        bias[2] = 8'sd10;
        bias[3] = -8'sd128;

        tbl[0]  = '{4'b0001, 19, 8'sd66, 4'b0001, 8'sd4, 8'sd4, 8'sd2, 8'sd66};
        tbl[1]  = '{4'b1000, 3, 8'sd17, 4'b1000, 8'sd48, 8'sd63, -8'sd128, 8'sd17};
        tbl[2]  = '{4'b1111, 4, -8'sd5, 4'b0001, 8'sd4, 8'sd4, 8'sd2, -8'sd5};
        tbl[3]  = '{4'b1110, 2, 8'sd100, 4'b0010, 8'sd16, 8'sd31, -8'sd3, 8'sd100};
        tbl[4]  = '{4'b1100, 6, -8'sd77, 4'b0100, 8'sd32, 8'sd47, 8'sd10, -8'sd77};
        tbl[5]  = '{4'b1000, 1, 8'sd3, 4'b1000, 8'sd48, 8'sd63, -8'sd128, 8'sd3};
        tbl[6]  = '{4'b1111, 2, 8'sd11, 4'b0001, 8'sd4, 8'sd4, 8'sd2, 8'sd11};
        tbl[7]  = '{4'b1111, 3, 8'sd12, 4'b0010, 8'sd16, 8'sd31, -8'sd3, 8'sd12};
        tbl[8]  = '{4'b1111, 2, 8'sd13, 4'b0100, 8'sd32, 8'sd47, 8'sd10, 8'sd13};
        tbl[9]  = '{4'b1111, 2, 8'sd14, 4'b1000, 8'sd48, 8'sd63, -8'sd128, 8'sd14};
        tbl[10] = '{4'b1111, 2, 8'sd15, 4'b0001, 8'sd4, 8'sd4, 8'sd2, 8'sd15};
        tbl[11] = '{4'b1111, 2, 8'sd16, 4'b0010, 8'sd16, 8'sd31, -8'sd3, 8'sd16};
        tbl[12] = '{4'b1000, 2, -8'sd1, 4'b1000, 8'sd48, 8'sd63, -8'sd128, -8'sd1};
        tbl[13] = '{4'b1001, 2, -8'sd2, 4'b0001, 8'sd4, 8'sd4, 8'sd2, -8'sd2};
        tbl[14] = '{4'b1001, 2, 8'sd127, 4'b1000, 8'sd48, 8'sd63, -8'sd128, 8'sd127};

        // Reset state
        tick();
        check("rst grant", grant_a, 4'b0000);
        check("rst busy", busy_a, 1'b0);
        check("rst done", done_a, 4'b0000);
        check("rst result", result_a, 8'sd0);
        check("rst launch", launch_a, 1'b0);
        check("rst err", err_a, 1'b0);
        tick();
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 15; v++) begin
            req_a = tbl[v].req;
            tick();
            check($sformatf("v%0d grant", v), grant_a, tbl[v].grant);
            check($sformatf("v%0d busy", v), busy_a, 1'b1);
            check($sformatf("v%0d no early launch", v), launch_a, 1'b0);
            tick();
            check($sformatf("v%0d launch", v), launch_a, 1'b1);
            check($sformatf("v%0d ext", v), ext_a, tbl[v].bias);
            check($sformatf("v%0d val0", v), avals_a[0], tbl[v].v0);
            check($sformatf("v%0d val15", v), avals_a[15], tbl[v].v15);
            early = 1'b0;
            for (int i = 1; i < tbl[v].lat; i++) begin
                tick();
                if (done_a != 4'b0000) early = 1'b1;
            end
            check($sformatf("v%0d early done", v), early, 1'b0);
            acc_val_a = tbl[v].acc;
            acc_vld_a = 1'b1;
            tick();
            acc_vld_a = 1'b0;
            acc_val_a = '0;
            check($sformatf("v%0d done", v), done_a, tbl[v].grant);
            check($sformatf("v%0d result", v), result_a, tbl[v].res);
            check($sformatf("v%0d err", v), err_a, 1'b0);
            check($sformatf("v%0d launch single", v), launch_a, 1'b0);
            check($sformatf("v%0d grant held", v), grant_a, tbl[v].grant);
            tick();
            check($sformatf("v%0d done pulse", v), done_a, 4'b0000);
            check($sformatf("v%0d grant drop", v), grant_a, 4'b0000);
            check($sformatf("v%0d idle", v), busy_a, 1'b0);
            check($sformatf("v%0d result hold", v), result_a, tbl[v].res);
        end

        // Requester drops its request right after grant; operation still completes.
        req_a = 4'b0100;
        tick();
        check("drop grant", grant_a, 4'b0100);
        req_a = 4'b0000;
        tick();
        tick();
        tick();
        acc_val_a = 8'sd55;
        acc_vld_a = 1'b1;
        tick();
        acc_vld_a = 1'b0;
        check("drop done", done_a, 4'b0100);
        check("drop result", result_a, 8'sd55);
        tick();

        // Normal op on the short-timeout instance so the abort's zero result is visible.
        req_b = 4'b0010;
        tick();
        check("wdA grant", grant_b, 4'b0010);
        tick();
        tick();
        acc_val_b = 8'sd7;
        acc_vld_b = 1'b1;
        tick();
        acc_vld_b = 1'b0;
        check("wdA done", done_b, 4'b0010);
        check("wdA result", result_b, 8'sd7);
        req_b = 4'b0000;
        tick();

        // Watchdog abort: accumulator never answers.
        req_b = 4'b0010;
        tick();
        tick();
        check("wd launch", launch_b, 1'b1);
        early = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done_b != 4'b0000 || err_b != 1'b0) early = 1'b1;
        end
        check("wd early", early, 1'b0);
        tick();
        check("wd done", done_b, 4'b0010);
        check("wd err", err_b, 1'b1);
        check("wd result", result_b, 8'sd0);
        req_b = 4'b0000;
        tick();
        check("wd done pulse", done_b, 4'b0000);
        check("wd err pulse", err_b, 1'b0);
        tick();
        tick();
        acc_val_b = 8'sd99;
        acc_vld_b = 1'b1;
        tick();
        acc_vld_b = 1'b0;
        check("late done", done_b, 4'b0000);
        tick();
        check("late done2", done_b, 4'b0000);
        check("late result", result_b, 8'sd0);
        check("late busy", busy_b, 1'b0);

        // Result arrives exactly on the timeout cycle.
        req_b = 4'b0010;
        tick();
        tick();
        for (int k = 1; k < 8; k++) tick();
        acc_val_b = 8'sd42;
        acc_vld_b = 1'b1;
        tick();
        acc_vld_b = 1'b0;
        check("tie done", done_b, 4'b0010);
        check("tie err", err_b, 1'b0);
        check("tie result", result_b, 8'sd42);
        req_b = 4'b0000;
        tick();

        // Asynchronous reset in the middle of WAIT.
        req_a = 4'b0100;
        tick();
        check("rstw grant", grant_a, 4'b0100);
        tick();
        tick();
        tick();
        req_a = 4'b0000;
        rstn = 1'b0;
        #1;
        check("rstw grant0", grant_a, 4'b0000);
        check("rstw busy0", busy_a, 1'b0);
        check("rstw result0", result_a, 8'sd0);
        check("rstw launch0", launch_a, 1'b0);
        check("rstw done0", done_a, 4'b0000);
        check("rstw err0", err_a, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        acc_val_a = 8'sd33;
        acc_vld_a = 1'b1;
        tick();
        acc_vld_a = 1'b0;
        check("rstw late done", done_a, 4'b0000);
        check("rstw late result", result_a, 8'sd0);
        req_a = 4'b1010;
        tick();
        check("rstw ptr0 grant", grant_a, 4'b0010);
        req_a = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
